heartbeat_pulse_gen: RTL and testbench
======================================

# heartbeat_pulse_gen

Consumes the 2-bit heartbeat rate code produced by the heartbeat model and turns it into a timed pulse train, one pulse per beat, that drives the heartbeat LED/output pin. A prescaler derives a slow tick from the system clock. A small beat FSM counts ticks to shape each pulse and each beat period. Rate changes take effect only at beat-period boundaries, so the visible rhythm never glitches.

## Interface
- TICK_DIV, 100000: system clocks per tick (≥2); prescaler width $clog2(TICK_DIV)
- PULSE_LEN, 8: ticks the beat output stays high per pulse
- PERIOD_CALM, 100: beat period in ticks for code 1
- PERIOD_NORMAL, 70: beat period in ticks for code 2
- PERIOD_RACING, 45: beat period in ticks for code 3
- GAP_LEN, 4: ticks between the two pulses of a double beat (used only with the macro)
- clk  input  1  system clock; all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- ena  input  1  global enable; low freezes prescaler, FSM and outputs
- heartbeat  input  2  rate code: 0 sleep, 1 calm, 2 normal, 3 racing
- beat  output  1  pulse train, high during each pulse
- beat_strobe  output  1  one-cycle strobe on the first cycle of each pulse
- rate_active  output  2  rate code currently applied by the FSM

## Operation
- Reset values: beat=0, beat_strobe=0, rate_active=0, FSM=IDLE, prescaler=0, phase=0, hb_req=0.
- heartbeat is registered into hb_req every enabled cycle, giving 1 cycle of input latency.
- Prescaler counts 0..TICK_DIV-1 while ena=1. tick=1 on the cycle it equals TICK_DIV-1, then it wraps to 0.
- The FSM advances only on tick cycles. phase is an 8-bit tick counter.
- Parameter constraints: PULSE_LEN < every period ≤ 255. With the macro, 2·PULSE_LEN+GAP_LEN < min period.
- IDLE: on a tick with hb_req≠0, latch rate_active=hb_req, set phase=0 and go to PULSE. If hb_req=0, stay.
- PULSE: beat=1. On a tick, phase++. When phase reaches PULSE_LEN-1 on a tick, go to REST.
- REST: beat=0. On a tick, phase++. When phase reaches period(rate_active)-1 on a tick, this is the boundary:
  - hb_req=0: go to IDLE, rate_active=0.
  - otherwise: rate_active=hb_req, phase=0, go to PULSE.
- A code change mid-period, including a change to 0, never aborts the current pulse or period. It applies at the next boundary.
- period() is a constant 3-way select on rate_active. Code 0 is never used for a period lookup.
- ena=0: all registers hold and outputs keep their current values. beat_strobe is forced 0.
- rst asserted mid-pulse: beat drops to 0 immediately (async).

## Timing
- beat and beat_strobe are registered. Both assert on the cycle after the tick that enters PULSE.
- beat_strobe is high for exactly 1 clock per pulse.
- Pulse high time is PULSE_LEN·TICK_DIV clocks. Period is period·TICK_DIV clocks.
- A heartbeat change reaches rate_active no earlier than the next boundary tick plus 1 cycle.
- From IDLE, the first beat starts on the first tick after hb_req≠0.
- No combinational path from inputs to outputs.

## Configuration
- HEARTBEAT_DOUBLE_EN defined: each period contains a "lub-dub" pair. The sequence is PULSE (PULSE_LEN) → GAP (GAP_LEN, beat=0) → PULSE2 (PULSE_LEN) → REST to the period end. beat_strobe fires at the start of both pulses.
- Undefined: single pulse per period. GAP and PULSE2 states and GAP_LEN are unused and not synthesized.

## Structure
- heartbeat_pkg holds:
  - rate code constants HB_SLEEP=0, HB_CALM=1, HB_NORMAL=2, HB_RACING=3
  - FSM state encoding: IDLE, PULSE, REST, GAP, PULSE2
- Sub-module tick_prescaler(clk, rst, ena → tick), parameterized by TICK_DIV. It is reused elsewhere for slow timebases.

## Test plan
Bench parameters: TICK_DIV=4, PULSE_LEN=2, PERIOD_CALM/NORMAL/RACING=12/8/6, GAP_LEN=1.
- Reset held, random heartbeat → beat=0, beat_strobe=0, rate_active=0. Pulse rst mid-pulse → beat drops asynchronously.
- heartbeat=2 from reset release, ena=1:
  - first beat_strobe follows the first tick
  - beat high for 8 clocks
  - strobes every 32 clocks
  - rate_active=2
- heartbeat 2→3 mid-REST:
  - current period still 32 clocks
  - following periods 24 clocks
  - rate_active changes to 3 at the boundary only
- heartbeat→0 during PULSE:
  - pulse completes (8 clocks high)
  - period finishes, then no further strobes
  - rate_active=0 after the boundary
- ena low for 10 clocks during REST → next strobe delayed by exactly 10 clocks; no strobe while ena=0.
- HEARTBEAT_DOUBLE_EN, heartbeat=1:
  - two strobes per 48-clock period, 12 clocks apart
  - each pulse 8 clocks high

Source files
------------

// File: rtl/heartbeat_pkg.sv
// Shared rate codes and beat-FSM state encoding for the heartbeat pulse generator.
package heartbeat_pkg;

    localparam logic [1:0] HB_SLEEP  = 2'd0;
    localparam logic [1:0] HB_CALM   = 2'd1;
    localparam logic [1:0] HB_NORMAL = 2'd2;
    localparam logic [1:0] HB_RACING = 2'd3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PULSE  = 3'd1,
        REST   = 3'd2,
        GAP    = 3'd3,
        PULSE2 = 3'd4
    } hb_state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle tick every TICK_DIV enabled clocks.
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    output logic tick
);

    localparam int unsigned     CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    assign tick = ena && (r_cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (ena) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/heartbeat_pulse_gen.sv
// Turns a 2-bit heartbeat rate code into a tick-timed LED pulse train.
// Define HEARTBEAT_DOUBLE_EN for a "lub-dub" double pulse in every beat period.
module heartbeat_pulse_gen
    import heartbeat_pkg::*;
#(
    parameter int unsigned TICK_DIV      = 100000,
    parameter int unsigned PULSE_LEN     = 8,
    parameter int unsigned PERIOD_CALM   = 100,
    parameter int unsigned PERIOD_NORMAL = 70,
    parameter int unsigned PERIOD_RACING = 45,
    parameter int unsigned GAP_LEN       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [1:0] heartbeat,
    output logic       beat,
    output logic       beat_strobe,
    output logic [1:0] rate_active
);

    localparam logic [7:0] PULSE_END = 8'(PULSE_LEN - 1);
`ifdef HEARTBEAT_DOUBLE_EN
    localparam logic [7:0] GAP_END    = 8'(PULSE_LEN + GAP_LEN - 1);
    localparam logic [7:0] PULSE2_END = 8'(2 * PULSE_LEN + GAP_LEN - 1);
`else
    // Single-pulse build has no gap phase.
    localparam int unsigned unused_gap_len = GAP_LEN;
`endif

    function automatic logic [7:0] period_end(input logic [1:0] rate);
        case (rate)
            HB_CALM:   period_end = 8'(PERIOD_CALM - 1);
            HB_NORMAL: period_end = 8'(PERIOD_NORMAL - 1);
            default:   period_end = 8'(PERIOD_RACING - 1);
        endcase
    endfunction

    hb_state_t  r_state;
    hb_state_t  w_state_nxt;
    logic [7:0] r_phase;
    logic [7:0] w_phase_nxt;
    logic [1:0] r_rate;
    logic [1:0] w_rate_nxt;
    logic [1:0] r_hb_req;
    logic       r_beat;
    logic       r_strobe;
    logic       w_enter_pulse;
    logic       w_beat_nxt;
    logic       w_tick;

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .ena (ena),
        .tick(w_tick)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_phase_nxt   = r_phase;
        w_rate_nxt    = r_rate;
        w_enter_pulse = 1'b0;
        if (w_tick) begin
            case (r_state)
                IDLE: begin
                    if (r_hb_req != HB_SLEEP) begin
                        w_rate_nxt    = r_hb_req;
                        w_phase_nxt   = 8'd0;
                        w_state_nxt   = PULSE;
                        w_enter_pulse = 1'b1;
                    end
                end
                PULSE: begin
                    w_phase_nxt = r_phase + 8'd1;
                    if (r_phase == PULSE_END) begin
`ifdef HEARTBEAT_DOUBLE_EN
                        w_state_nxt = GAP;
`else
                        w_state_nxt = REST;
`endif
                    end
                end
`ifdef HEARTBEAT_DOUBLE_EN
                GAP: begin
                    w_phase_nxt = r_phase + 8'd1;
                    if (r_phase == GAP_END) begin
                        w_state_nxt   = PULSE2;
                        w_enter_pulse = 1'b1;
                    end
                end
                PULSE2: begin
                    w_phase_nxt = r_phase + 8'd1;
                    if (r_phase == PULSE2_END) begin
                        w_state_nxt = REST;
                    end
                end
`endif
                REST: begin
                    // Beat-period boundary: the only place a new rate is adopted.
                    if (r_phase == period_end(r_rate)) begin
                        w_phase_nxt = 8'd0;
                        if (r_hb_req == HB_SLEEP) begin
                            w_rate_nxt  = HB_SLEEP;
                            w_state_nxt = IDLE;
                        end else begin
                            w_rate_nxt    = r_hb_req;
                            w_state_nxt   = PULSE;
                            w_enter_pulse = 1'b1;
                        end
                    end else begin
                        w_phase_nxt = r_phase + 8'd1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_phase_nxt = 8'd0;
                    w_rate_nxt  = HB_SLEEP;
                end
            endcase
        end
    end

    assign w_beat_nxt = (w_state_nxt == PULSE) || (w_state_nxt == PULSE2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_phase  <= 8'd0;
            r_rate   <= HB_SLEEP;
            r_hb_req <= HB_SLEEP;
            r_beat   <= 1'b0;
            r_strobe <= 1'b0;
        end else begin
            r_strobe <= w_enter_pulse;
            if (ena) begin
                r_hb_req <= heartbeat;
                r_state  <= w_state_nxt;
                r_phase  <= w_phase_nxt;
                r_rate   <= w_rate_nxt;
                r_beat   <= w_beat_nxt;
            end
        end
    end

    assign beat        = r_beat;
    assign beat_strobe = r_strobe;
    assign rate_active = r_rate;

endmodule

// File: tb/tb_heartbeat_pulse_gen.sv
// Directed run-length vector bench for heartbeat_pulse_gen (TICK_DIV=4, PULSE_LEN=2, periods 12/8/6).
module tb_heartbeat_pulse_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b1;
    logic [1:0] heartbeat = 2'd0;
    logic       beat;
    logic       beat_strobe;
    logic [1:0] rate_active;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0]  hb;
        logic        en;
        int unsigned n;
        logic        exp_beat;
        logic        exp_strobe;
        logic [1:0]  exp_rate;
    } seg_t;

    seg_t tbl[$];

    heartbeat_pulse_gen #(
        .TICK_DIV     (4),
        .PULSE_LEN    (2),
        .PERIOD_CALM  (12),
        .PERIOD_NORMAL(8),
        .PERIOD_RACING(6),
        .GAP_LEN      (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .heartbeat  (heartbeat),
        .beat       (beat),
        .beat_strobe(beat_strobe),
        .rate_active(rate_active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic [1:0] hb, input logic en, input int unsigned n,
                       input logic b, input logic s, input logic [1:0] r);
        seg_t t;
        t.hb = hb; t.en = en; t.n = n;
        t.exp_beat = b; t.exp_strobe = s; t.exp_rate = r;
        tbl.push_back(t);
    endtask

    initial begin
        int first_strobe;
        int interval;
        bit seen;

`ifdef HEARTBEAT_DOUBLE_EN
        add(2'd1, 1'b1, 3,  1'b0, 1'b0, 2'd0);
        add(2'd1, 1'b1, 1,  1'b1, 1'b1, 2'd1);
        add(2'd1, 1'b1, 7,  1'b1, 1'b0, 2'd1);
        add(2'd1, 1'b1, 4,  1'b0, 1'b0, 2'd1);
        add(2'd1, 1'b1, 1,  1'b1, 1'b1, 2'd1);
        add(2'd1, 1'b1, 7,  1'b1, 1'b0, 2'd1);
        add(2'd1, 1'b1, 28, 1'b0, 1'b0, 2'd1);
        add(2'd1, 1'b1, 1,  1'b1, 1'b1, 2'd1);
        add(2'd1, 1'b1, 5,  1'b1, 1'b0, 2'd1);
`else
        add(2'd2, 1'b1, 3,  1'b0, 1'b0, 2'd0);
        add(2'd2, 1'b1, 1,  1'b1, 1'b1, 2'd2);
        add(2'd2, 1'b1, 7,  1'b1, 1'b0, 2'd2);
        add(2'd2, 1'b1, 24, 1'b0, 1'b0, 2'd2);
        add(2'd2, 1'b1, 1,  1'b1, 1'b1, 2'd2);
        add(2'd2, 1'b1, 7,  1'b1, 1'b0, 2'd2);
        add(2'd2, 1'b1, 6,  1'b0, 1'b0, 2'd2);
        add(2'd3, 1'b1, 18, 1'b0, 1'b0, 2'd2);
        add(2'd3, 1'b1, 1,  1'b1, 1'b1, 2'd3);
        add(2'd3, 1'b1, 7,  1'b1, 1'b0, 2'd3);
        add(2'd3, 1'b1, 16, 1'b0, 1'b0, 2'd3);
        add(2'd3, 1'b1, 1,  1'b1, 1'b1, 2'd3);
        add(2'd0, 1'b1, 7,  1'b1, 1'b0, 2'd3);
        add(2'd0, 1'b1, 16, 1'b0, 1'b0, 2'd3);
        add(2'd0, 1'b1, 40, 1'b0, 1'b0, 2'd0);
        add(2'd2, 1'b1, 4,  1'b0, 1'b0, 2'd0);
        add(2'd2, 1'b1, 1,  1'b1, 1'b1, 2'd2);
        add(2'd2, 1'b1, 7,  1'b1, 1'b0, 2'd2);
        add(2'd2, 1'b1, 12, 1'b0, 1'b0, 2'd2);
        add(2'd2, 1'b0, 10, 1'b0, 1'b0, 2'd2);
        add(2'd2, 1'b1, 12, 1'b0, 1'b0, 2'd2);
        add(2'd2, 1'b1, 1,  1'b1, 1'b1, 2'd2);
        add(2'd2, 1'b1, 5,  1'b1, 1'b0, 2'd2);
`endif

        // Reset held with arbitrary heartbeat codes.
        for (int i = 0; i < 5; i++) begin
            heartbeat = 2'($urandom_range(3, 0));
            @(posedge clk);
            @(negedge clk);
            chk("rst.beat",   int'(beat),        0);
            chk("rst.strobe", int'(beat_strobe), 0);
            chk("rst.rate",   int'(rate_active), 0);
        end
        rst = 1'b0;

        for (int s = 0; s < tbl.size(); s++) begin
            for (int c = 0; c < int'(tbl[s].n); c++) begin
                heartbeat = tbl[s].hb;
                ena       = tbl[s].en;
                @(posedge clk);
                @(negedge clk);
                chk($sformatf("seg%0d.cyc%0d.beat", s, c),   int'(beat),        int'(tbl[s].exp_beat));
                chk($sformatf("seg%0d.cyc%0d.strobe", s, c), int'(beat_strobe), int'(tbl[s].exp_strobe));
                chk($sformatf("seg%0d.cyc%0d.rate", s, c),   int'(rate_active), int'(tbl[s].exp_rate));
            end
        end

        // Asynchronous reset in the middle of a pulse.
        #2 rst = 1'b1;
        #1;
        chk("async_rst.beat",   int'(beat),        0);
        chk("async_rst.strobe", int'(beat_strobe), 0);
        chk("async_rst.rate",   int'(rate_active), 0);
        @(negedge clk);
        rst       = 1'b0;
        ena       = 1'b1;
        heartbeat = 2'd3;

        // Restart at racing rate: first strobe on the 4th clock, then every 24 clocks.
        first_strobe = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (beat_strobe) begin
                first_strobe = i;
                break;
            end
        end
        chk("restart.first_strobe_cycle", first_strobe, 4);

        interval = -1;
        seen = 1'b0;
        if (first_strobe > 0) begin
            for (int i = 1; i <= 40 && !seen; i++) begin
                @(posedge clk);
                @(negedge clk);
                if (beat_strobe) begin
                    interval = i;
                    seen = 1'b1;
                end
            end
        end
        chk("restart.strobe_interval", interval, 24);
        chk("restart.rate", int'(rate_active), 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
